// File: rtl/demux4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer slice.
package demux4_buf_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/demux4_buf_dec2to4.sv
// 2-bit select to 4-bit one-hot; bit ordering matches the 4-way mux select.
module dec2to4
    import demux4_buf_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot
);

    assign onehot = NUM_CH'(1) << sel;

endmodule

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demux: one holding register per channel with per-channel backpressure.
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [CNT_W-1:0]        xfer_count
);

    logic [NUM_CH-1:0] sel_oh_p0;
    logic [NUM_CH-1:0] load_p0;
    logic              accept_p0;
    logic [CNT_W-1:0]  cnt_p1;

    // A full channel still accepts when its consumer drains in the same cycle.
    assign in_ready  = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept_p0 = in_valid & in_ready;

    dec2to4 u_dec (
        .sel    (in_sel),
        .onehot (sel_oh_p0)
    );

    assign load_p0 = sel_oh_p0 & {NUM_CH{accept_p0}};

    // ---- stage p0 -> p1: per-channel holding registers ----
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] data_p1;
        logic             vld_p1;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end else begin
                if (load_p0[k]) begin
                    vld_p1  <= 1'b1;
                    data_p1 <= in_data;
                end else if (out_ready[k]) begin
                    vld_p1  <= 1'b0;
                end
            end
        end

        assign out_valid[k]                 = vld_p1;
        assign out_data[k*WIDTH +: WIDTH]   = data_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else if (accept_p0) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign xfer_count = cnt_p1;

endmodule

// File: doc/demux4_buf.md
# demux4_buf

Buffered 1-to-4 demultiplexer: accepts a data word plus a 2-bit channel select on a valid/ready input port and delivers it to one of four independent output channels, each holding one word until its consumer takes it. It is the distribution side of the 4-way select datapath, using the same select encoding as the 4-input mux: 00→ch0, 01→ch1, 10→ch2, 11→ch3. It sits between a single producer and four downstream consumers and provides per-channel backpressure.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination channel, 00/01/10/11 → ch0/ch1/ch2/ch3
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block accepts this cycle; transfer = in_valid & in_ready
- out_data  output  4*WIDTH  channel k word at [k*WIDTH +: WIDTH]
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word this cycle
- xfer_count  output  16  number of accepted input transfers, wraps

## Operation
- Each channel k has one holding register (data_k, valid_k); out_data/out_valid are driven directly from these registers.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready and is computed regardless of in_valid.
- Accept (in_valid & in_ready): at the next edge, data_{in_sel} ← in_data and valid_{in_sel} ← 1.
- Drain (out_valid[k] & out_ready[k]) with no load to k: valid_k ← 0. data_k holds its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one and valid_k stays 1, so there is no bubble.
- Channels not selected drain independently in the same cycle. Any combination of the 4 out_ready bits is legal.
- out_ready[k] while out_valid[k]=0 is ignored.
- in_valid=0: no state changes except drains. in_sel is don't-care.
- xfer_count increments by 1 on every accepted transfer and wraps from 0xFFFF to 0x0000.
- Per-channel order is preserved trivially because each channel holds one word. There is no ordering guarantee across channels.

## Timing
- Reset (synchronous, active-high, dominates all other inputs):
  - next edge: out_valid=4'b0000, out_data=0, xfer_count=0.
  - in_ready then reads 1 for any in_sel.
- Reset mid-operation: all buffered words are discarded and never presented. A transfer that handshakes in the reset cycle is not accepted and not counted.
- Latency: a word accepted at edge N shows out_valid[k]=1 and out_data valid in the cycle after edge N (1 cycle).
- Throughput:
  - one word per cycle to distinct channels;
  - one word per cycle to the same channel only while that consumer holds out_ready=1.
- Full channel (out_valid[k]=1, out_ready[k]=0) with in_sel=k: in_ready=0. The producer must hold in_data/in_sel/in_valid stable until accepted.
- Output stability: while out_valid[k]=1 & out_ready[k]=0, out_data channel k must not change.

## Structure
- Shared package constants: NUM_CH=4, SEL_W=2, CNT_W=16.
- Sub-module dec2to4: 2-bit select → 4-bit one-hot. It is the inverse of the 4-way mux select and reuses the same bit ordering.
  - Output is gated with the accept condition to form per-channel load enables.
- The 4 channel registers are a generate loop over NUM_CH. No FSM beyond the per-channel valid bits.

## Test plan
- Reset:
  - stimulus: assert reset for 2 cycles with in_valid=1, in_sel=01, in_data=0xAA.
  - response: out_valid=0000, out_data=0, xfer_count=0, and no word appears after release.
- Fan-out:
  - stimulus: send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with sel 00, 01, 10, 11 and out_ready=0000.
  - response: all accepted; out_valid=1111; channels 0–3 hold 0x11/0x22/0x33/0x44; xfer_count=4.
- Backpressure:
  - stimulus: channel 2 full, out_ready[2]=0, in_valid=1, in_sel=10, in_data=0x55.
  - response: in_ready=0 and channel 2 keeps 0x33.
  - follow-up: raise out_ready[2] for one cycle.
  - response: 0x55 loads, out_valid[2] stays 1, xfer_count increments once.
- Streaming:
  - stimulus: out_ready[1]=1 permanently; 8 back-to-back words 0x01..0x08 to sel 01.
  - response: in_ready=1 every cycle; channel 1 presents 0x01..0x08 in order, one per cycle, 1-cycle latency.
- Independent drain:
  - stimulus: all channels full, pulse out_ready=0101 for one cycle with in_valid=0.
  - response: out_valid=1010 next cycle, with channel 1 and channel 3 data unchanged.
- Counter wrap:
  - stimulus: 65537 accepted transfers.
  - response: xfer_count reads 0xFFFF after 65535, 0x0000 after 65536, and 0x0001 after 65537.
